scoreboard_reg_file: RTL and testbench
======================================

SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero and is never busy.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning a same-cycle write is forwarded to the read ports.
REQ-005 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have ports reg1 and reg2, input, ADDR_W bits each, the read addresses.
REQ-008 The block SHALL have ports ReadData1 and ReadData2, output, DATA_W bits each, the read data.
REQ-009 The block SHALL have port wrAddr, input, ADDR_W bits, the write-back address.
REQ-010 The block SHALL have port writeData, input, DATA_W bits, the write-back data.
REQ-011 The block SHALL have port RegWrite, input, 1 bit, the write-back strobe.
REQ-012 The block SHALL have port issueAddr, input, ADDR_W bits, the destination register of the issuing instruction.
REQ-013 The block SHALL have port issueValid, input, 1 bit, the strobe that marks issueAddr busy.
REQ-014 The block SHALL have ports Busy1 and Busy2, output, 1 bit each, the pending-write flags for reg1 and reg2.
REQ-015 The block SHALL have port PendingCount, output, ADDR_W+1 bits, the number of busy registers.

Function
REQ-016 Reads SHALL be combinational: ReadDataN = regs[regN] in the same cycle.
REQ-017 With RegWrite=1, regs[wrAddr] SHALL take writeData at the rising edge of Clk.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and issues to address 0 SHALL not set busy.
REQ-019 With BYPASS=1, RegWrite=1 and wrAddr==regN (nonzero when ZERO_REG=1), ReadDataN SHALL equal writeData in that cycle and BusyN SHALL be 0 in that cycle.
REQ-020 With BYPASS=0, reads SHALL return the pre-edge register value and BusyN SHALL reflect the pre-edge busy bit.
REQ-021 The scoreboard SHALL hold one busy bit per register; issueValid SHALL set busy[issueAddr] at the edge, and RegWrite SHALL clear busy[wrAddr] at the edge.
REQ-022 When a set and a clear target the same address in one cycle, set SHALL win, so the register stays busy for the new producer.
REQ-023 A set of a register that is already busy SHALL leave it busy and leave PendingCount unchanged.
REQ-024 A clear of a register that is not busy SHALL still perform the data write and leave PendingCount unchanged.
REQ-025 PendingCount SHALL be registered and SHALL equal the population count of the busy bits after each edge.
REQ-026 A simultaneous set on address A and clear on address B, with A != B, SHALL leave PendingCount unchanged when both bits change.
REQ-027 PendingCount SHALL never exceed NUM_REGS, or NUM_REGS-1 when ZERO_REG=1.

Reset
REQ-028 With Reset=1 at a rising edge, all registers SHALL become 0, all busy bits 0, and PendingCount 0.
REQ-029 Reset SHALL take priority over a write or issue in the same cycle; those events SHALL be discarded.
REQ-030 After reset, ReadData1/2 SHALL read 0 and Busy1/2 SHALL be 0 for every address.

Verification
REQ-031 Reset, then RegWrite=1, wrAddr=15, writeData=0x1871 for one edge; then reg1=15 -> ReadData1=0x1871, Busy1=0.
REQ-032 issueValid=1, issueAddr=16 for one edge; reg2=16 -> Busy2=1, PendingCount=1; then RegWrite, wrAddr=16, writeData=0x1249 -> in that cycle ReadData2=0x1249 and Busy2=0 (BYPASS=1); after the edge PendingCount=0.
REQ-033 Same cycle: issueValid on address 7 and RegWrite on address 7, with 7 already busy -> 7 remains busy and PendingCount is unchanged.
REQ-034 ZERO_REG=1: write 0xFFFFFFFF to address 0 and issue address 0 -> ReadData1 at reg1=0 reads 0, Busy1=0, PendingCount=0.
REQ-035 Issue addresses 1..5, then Reset=1 together with RegWrite on address 3 -> all busy bits 0, PendingCount=0, and register 3 reads 0.
REQ-036 Build with DATA_W=16, ADDR_W=3, BYPASS=0 and issue all of 1..7 -> PendingCount=7; a same-cycle write-then-read returns the old value and Busy=1 until the edge.

Source files
------------

// File: rtl/scoreboard_reg_file.sv
// Register file with a per-register busy scoreboard for in-order issue.
// Tracks pending writers and forwards same-cycle write-back to reads.
module scoreboard_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic              issueValid,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    pend_q;
  logic [CNT_W-1:0]    pend_d;

  logic wr_zero;
  logic iss_zero;
  logic wr_en;
  logic iss_en;

  assign wr_zero  = (ZERO_REG != 0) && (wrAddr == '0);
  assign iss_zero = (ZERO_REG != 0) && (issueAddr == '0);
  assign wr_en    = RegWrite && !wr_zero;
  assign iss_en   = issueValid && !iss_zero;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wrAddr] = writeData;
    end
  end

  // Clear first, then set, so a new producer wins over the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wrAddr] = 1'b0;
    end
    if (iss_en) begin
      busy_d[issueAddr] = 1'b1;
    end
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d = pend_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  logic fwd1;
  logic fwd2;
  logic zr1;
  logic zr2;

  assign fwd1 = (BYPASS != 0) && wr_en && (wrAddr == reg1);
  assign fwd2 = (BYPASS != 0) && wr_en && (wrAddr == reg2);
  assign zr1  = (ZERO_REG != 0) && (reg1 == '0);
  assign zr2  = (ZERO_REG != 0) && (reg2 == '0);

  always_comb begin
    ReadData1 = regs_q[reg1];
    Busy1     = busy_q[reg1];
    if (fwd1) begin
      ReadData1 = writeData;
      Busy1     = 1'b0;
    end
    if (zr1) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
  end

  always_comb begin
    ReadData2 = regs_q[reg2];
    Busy2     = busy_q[reg2];
    if (fwd2) begin
      ReadData2 = writeData;
      Busy2     = 1'b0;
    end
    if (zr2) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

  assign PendingCount = pend_q;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Bench for scoreboard_reg_file: directed cases plus random traffic
// against an array-based reference model.
module tb_scoreboard_reg_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  reg1, reg2, wrAddr, issueAddr;
  logic [31:0] writeData;
  logic        RegWrite, issueValid;
  logic [31:0] ReadData1, ReadData2;
  logic        Busy1, Busy2;
  logic [5:0]  PendingCount;

  logic [2:0]  b_reg1, b_reg2, b_wa, b_ia;
  logic [15:0] b_wd;
  logic        b_we, b_iv;
  logic [15:0] b_rd1, b_rd2;
  logic        b_busy1, b_busy2;
  logic [3:0]  b_pend;

  always #5 Clk = ~Clk;

  scoreboard_reg_file dut (
    .Clk(Clk), .Reset(Reset),
    .reg1(reg1), .reg2(reg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .wrAddr(wrAddr), .writeData(writeData), .RegWrite(RegWrite),
    .issueAddr(issueAddr), .issueValid(issueValid),
    .Busy1(Busy1), .Busy2(Busy2), .PendingCount(PendingCount)
  );

  scoreboard_reg_file #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .Clk(Clk), .Reset(Reset),
    .reg1(b_reg1), .reg2(b_reg2),
    .ReadData1(b_rd1), .ReadData2(b_rd2),
    .wrAddr(b_wa), .writeData(b_wd), .RegWrite(b_we),
    .issueAddr(b_ia), .issueValid(b_iv),
    .Busy1(b_busy1), .Busy2(b_busy2), .PendingCount(b_pend)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pop();
    int n = 0;
    foreach (mbusy[i]) n += int'(mbusy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite && wrAddr == a) return writeData;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (RegWrite && wrAddr == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic model_edge();
    if (Reset) begin
      foreach (mregs[i]) begin
        mregs[i] = 32'h0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (RegWrite && wrAddr != 0) begin
        mregs[wrAddr] = writeData;
        mbusy[wrAddr] = 1'b0;
      end
      if (issueValid && issueAddr != 0) mbusy[issueAddr] = 1'b1;
    end
  endtask

  // One clock: combinational checks mid-cycle, then count after the edge.
  task automatic cycle();
    @(negedge Clk);
    chk("rd1", ReadData1, exp_rd(reg1));
    chk("rd2", ReadData2, exp_rd(reg2));
    chk("busy1", 32'(Busy1), 32'(exp_busy(reg1)));
    chk("busy2", 32'(Busy2), 32'(exp_busy(reg2)));
    @(posedge Clk);
    model_edge();
    #1;
    chk("pend", 32'(PendingCount), 32'(pop()));
  endtask

  task automatic idle();
    Reset = 0; RegWrite = 0; issueValid = 0;
    wrAddr = 0; issueAddr = 0; writeData = 0;
  endtask

  initial begin
    idle();
    reg1 = 0; reg2 = 0;
    b_reg1 = 0; b_reg2 = 0; b_wa = 0; b_ia = 0;
    b_wd = 0; b_we = 0; b_iv = 0;
    foreach (mregs[i]) begin
      mregs[i] = 32'h0;
      mbusy[i] = 1'b0;
    end

    Reset = 1;
    @(posedge Clk);
    #1;
    Reset = 0;
    chk("rst_pend", 32'(PendingCount), 32'h0);
    for (int a = 0; a < 32; a++) begin
      reg1 = 5'(a); reg2 = 5'(31 - a);
      cycle();
    end

    RegWrite = 1; wrAddr = 15; writeData = 32'h1871;
    cycle();
    idle(); reg1 = 15; #1;
    chk("req31_rd1", ReadData1, 32'h1871);
    chk("req31_busy1", 32'(Busy1), 32'h0);

    issueValid = 1; issueAddr = 16;
    cycle();
    idle(); reg2 = 16; #1;
    chk("req32_busy2", 32'(Busy2), 32'h1);
    chk("req32_pend1", 32'(PendingCount), 32'h1);
    RegWrite = 1; wrAddr = 16; writeData = 32'h1249; #1;
    chk("req32_byp_rd2", ReadData2, 32'h1249);
    chk("req32_byp_busy2", 32'(Busy2), 32'h0);
    cycle();
    idle();
    chk("req32_pend0", 32'(PendingCount), 32'h0);

    issueValid = 1; issueAddr = 7;
    cycle();
    issueValid = 1; issueAddr = 7;
    RegWrite = 1; wrAddr = 7; writeData = 32'h55;
    cycle();
    idle(); reg1 = 7; #1;
    chk("req33_busy1", 32'(Busy1), 32'h1);
    chk("req33_pend", 32'(PendingCount), 32'h1);
    RegWrite = 1; wrAddr = 7; writeData = 32'h66;
    cycle();
    idle();

    RegWrite = 1; wrAddr = 0; writeData = 32'hFFFF_FFFF;
    issueValid = 1; issueAddr = 0;
    cycle();
    idle(); reg1 = 0; #1;
    chk("req34_rd1", ReadData1, 32'h0);
    chk("req34_busy1", 32'(Busy1), 32'h0);
    chk("req34_pend", 32'(PendingCount), 32'h0);

    for (int a = 1; a <= 5; a++) begin
      issueValid = 1; issueAddr = 5'(a);
      cycle();
    end
    idle();
    chk("req35_pend5", 32'(PendingCount), 32'h5);
    Reset = 1; RegWrite = 1; wrAddr = 3; writeData = 32'h3333;
    cycle();
    idle(); reg1 = 3; #1;
    chk("req35_rd1", ReadData1, 32'h0);
    chk("req35_pend", 32'(PendingCount), 32'h0);
    for (int a = 1; a <= 5; a++) begin
      reg1 = 5'(a); reg2 = 5'(a);
      cycle();
    end

    for (int n = 0; n < 400; n++) begin
      Reset      = ($urandom_range(0, 59) == 0);
      reg1       = 5'($urandom_range(0, 31));
      reg2       = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
      RegWrite   = 1'($urandom_range(0, 1));
      wrAddr     = 5'($urandom_range(0, 11));
      writeData  = $urandom;
      issueValid = 1'($urandom_range(0, 1));
      issueAddr  = 5'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) reg1 = wrAddr;
      cycle();
    end
    idle();

    Reset = 1;
    @(posedge Clk);
    #1;
    Reset = 0;
    for (int a = 1; a <= 7; a++) begin
      b_iv = 1; b_ia = 3'(a);
      @(posedge Clk);
      #1;
    end
    b_iv = 0;
    chk("req36_pend7", 32'(b_pend), 32'h7);
    b_reg1 = 3; b_we = 1; b_wa = 3; b_wd = 16'hABCD; #1;
    chk("req36_old_rd", 32'(b_rd1), 32'h0);
    chk("req36_old_busy", 32'(b_busy1), 32'h1);
    @(posedge Clk);
    #1;
    b_we = 0; #1;
    chk("req36_new_rd", 32'(b_rd1), 32'hABCD);
    chk("req36_new_busy", 32'(b_busy1), 32'h0);
    chk("req36_pend6", 32'(b_pend), 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
